// File: rtl/fp_div_scheduler.sv
// Round-robin front end sharing one pipelined FP divider among NREQ requesters.
// A tag FIFO remembers who issued each in-flight operation so quotients go home.
module fp_div_scheduler #(
  parameter int NREQ      = 4,
  parameter int DIV_LAT   = 28,
  parameter int TAG_DEPTH = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*32-1:0] req_dataa_i,
  input  logic [NREQ*32-1:0] req_datab_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              div_tvalid_o,
  output logic [31:0]       div_dataa_o,
  output logic [31:0]       div_datab_o,
  input  logic              div_result_tvalid_i,
  input  logic [31:0]       div_result_tdata_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              dbg_state_o
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(DIV_LAT + 2);

  // Handshake: a requester holds valid and data stable until it sees ready;
  // the transfer happens on the rising edge where valid & ready are both high.
  typedef enum logic {ST_DRAIN = 1'b0, ST_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   drain_q, drain_d;

  logic [IW-1:0]   last_q;
  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic [31:0]     arb_a, arb_b;
  logic            grant;

  logic            div_tvalid_q;
  logic [31:0]     div_dataa_q, div_datab_q;

  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fifo_cnt_q, fifo_cnt_d;
  logic            fifo_full, push, pop, orphan, overflow;
  logic [IW-1:0]   head_tag;
  logic [NREQ-1:0] head_vec;

  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            err_q;

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_DRAIN;
      drain_q <= CW'(DIV_LAT + 1);
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next state: the divider has no reset, so wait out its pipeline first
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_RUN;
        else drain_d = drain_q - CW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Round-robin: first pass above last grant, second pass wraps around
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_a     = '0;
    arb_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req_valid_i[i] && (IW'(i) > last_q)) begin
        arb_found = 1'b1;
        arb_idx   = IW'(i);
        arb_a     = req_dataa_i[32*i +: 32];
        arb_b     = req_datab_i[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req_valid_i[i]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(i);
        arb_a     = req_dataa_i[32*i +: 32];
        arb_b     = req_datab_i[32*i +: 32];
      end
    end
  end

  // Outputs of the FSM
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = (state_q == ST_RUN) && arb_found && (arb_idx == IW'(i));
    end
    busy_o      = (state_q == ST_DRAIN) || (fifo_cnt_q != '0) || (|rsp_valid_q);
    dbg_state_o = state_q;
  end

  assign grant     = (state_q == ST_RUN) && arb_found;
  assign fifo_full = (fifo_cnt_q == (AW+1)'(TAG_DEPTH));
  assign pop       = (state_q == ST_RUN) && div_result_tvalid_i && (fifo_cnt_q != '0);
  assign orphan    = (state_q == ST_RUN) && div_result_tvalid_i && (fifo_cnt_q == '0);
  // A same-edge pop frees the slot, so a full FIFO can still take the push
  assign push      = grant && (!fifo_full || pop);
  assign overflow  = grant && fifo_full && !pop;
  assign head_tag  = tag_mem[rd_ptr_q];

  always_comb begin
    head_vec = '0;
    for (int i = 0; i < NREQ; i++) head_vec[i] = (head_tag == IW'(i));
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_q       <= IW'(NREQ - 1);
      div_tvalid_q <= 1'b0;
      div_dataa_q  <= '0;
      div_datab_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      div_tvalid_q <= grant;
      if (grant) begin
        last_q      <= arb_idx;
        div_dataa_q <= arb_a;
        div_datab_q <= arb_b;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_cnt_q  <= fifo_cnt_d;
      rsp_valid_q <= pop ? head_vec : '0;
      if (pop) rsp_data_q <= div_result_tdata_i;
      if (orphan || overflow) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock_i) begin
    if (push) tag_mem[wr_ptr_q] <= arb_idx;
  end

  assign div_tvalid_o = div_tvalid_q;
  assign div_dataa_o  = div_dataa_q;
  assign div_datab_o  = div_datab_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Bench for fp_div_scheduler: behavioural divider pipeline, round-robin model
// and an expected-response queue checked as quotients come back.
module tb_fp_div_scheduler;

  localparam int NREQ = 4;
  localparam int DIV_LAT = 28;
  localparam int TAG_DEPTH = 32;
  localparam int W = 36;
  localparam int MAXOPS = 64;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*32-1:0] req_dataa, req_datab;
  logic [NREQ-1:0] req_ready;
  logic div_tvalid;
  logic [31:0] div_dataa, div_datab;
  logic div_result_tvalid;
  logic [31:0] div_result_tdata;
  logic [NREQ-1:0] rsp_valid;
  logic [31:0] rsp_data;
  logic busy, err, dbg_state;

  fp_div_scheduler #(.NREQ(NREQ), .DIV_LAT(DIV_LAT), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clock_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_dataa_i(req_dataa), .req_datab_i(req_datab),
    .req_ready_o(req_ready),
    .div_tvalid_o(div_tvalid), .div_dataa_o(div_dataa), .div_datab_o(div_datab),
    .div_result_tvalid_i(div_result_tvalid), .div_result_tdata_i(div_result_tdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .busy_o(busy), .err_o(err), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=timeout required=done", name);
  endtask

  // behavioural single-precision divider (normal operands only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  logic [DIV_LAT-1:0] pv = '0;
  logic [31:0] pd [DIV_LAT];
  logic inj_v = 1'b0;
  logic [31:0] inj_d = '0;

  always @(posedge clk) begin
    pv <= {pv[DIV_LAT-2:0], div_tvalid};
    pd[0] <= div_tvalid ? r2f(f2r(div_dataa) / f2r(div_datab)) : 32'h0;
    for (int k = 1; k < DIV_LAT; k++) pd[k] <= pd[k-1];
  end
  assign div_result_tvalid = pv[DIV_LAT-1] | inj_v;
  assign div_result_tdata  = inj_v ? inj_d : pd[DIV_LAT-1];

  // driver state
  logic [31:0] op_a [NREQ][MAXOPS];
  logic [31:0] op_b [NREQ][MAXOPS];
  logic [31:0] op_q [NREQ][MAXOPS];
  int op_n [NREQ];
  int op_i [NREQ];
  logic [31:0] exp_quot [NREQ];

  task automatic clear_ops();
    for (int i = 0; i < NREQ; i++) begin op_n[i] = 0; op_i[i] = 0; end
  endtask

  task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    op_a[r][op_n[r]] = a;
    op_b[r][op_n[r]] = b;
    op_q[r][op_n[r]] = q;
    op_n[r]++;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (op_i[i] < op_n[i]) begin
        req_valid[i] = 1'b1;
        req_dataa[32*i +: 32] = op_a[i][op_i[i]];
        req_datab[32*i +: 32] = op_b[i][op_i[i]];
        exp_quot[i] = op_q[i][op_i[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++) if (op_i[i] < op_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  // called at posedge+1; returns once every queued op has been accepted
  task automatic run_ops(input int budget);
    logic [NREQ-1:0] acc;
    for (int c = 0; c < budget; c++) begin
      apply_inputs();
      if (all_done()) return;
      @(negedge clk);
      acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) if (acc[i]) op_i[i]++;
      @(posedge clk); #1;
    end
    fail_now("run_ops_timeout");
    clear_ops();
    apply_inputs();
  endtask

  // scoreboard and round-robin model
  logic [W-1:0] exp_q [$];
  int grant_log [$];
  int drain_m, last_m, cyc, first_ready_cyc, acc_cyc, rsp_cyc;
  logic [NREQ-1:0] last_rsp_v;
  logic [31:0] last_rsp_d;
  logic busy_at_rsp, busy_after_rsp, prev_rsp;

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, ev;
    logic [W-1:0] e;
    int gidx;
    if (reset) begin
      drain_m = DIV_LAT + 2;
      last_m = NREQ - 1;
      exp_q.delete();
      cyc = 0;
      first_ready_cyc = -1;
      prev_rsp = 1'b0;
    end else begin
      eg = '0;
      gidx = 0;
      if (drain_m == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (last_m + 1 + k) % NREQ;
          if (eg == '0 && req_valid[idx]) begin eg[idx] = 1'b1; gidx = idx; end
        end
      end
      check("req_ready", 64'(req_ready), 64'(eg));
      if (eg != '0) begin
        exp_q.push_back({4'(gidx), exp_quot[gidx]});
        last_m = gidx;
        acc_cyc = cyc;
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
      if (req_ready != '0 && first_ready_cyc < 0) first_ready_cyc = cyc;
      if (drain_m > 0) drain_m--;
      if (prev_rsp) busy_after_rsp = busy;
      prev_rsp = (rsp_valid != '0);
      if (rsp_valid != '0) begin
        rsp_cyc = cyc;
        last_rsp_v = rsp_valid;
        last_rsp_d = rsp_data;
        busy_at_rsp = busy;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'h0);
        end else begin
          e = exp_q.pop_front();
          ev = NREQ'(1) << e[35:32];
          check("rsp_valid", 64'(rsp_valid), 64'(ev));
          check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
        end
      end
      cyc++;
    end
  end

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin @(negedge clk); c++; end
    if (exp_q.size() != 0) fail_now("wait_idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } vec_t;
  vec_t vt [8];

  initial begin
    logic [31:0] a, b, q;
    int k;
    vt[0] = '{0, 32'h3F800000, 32'h40800000, 32'h3E800000}; // 1/4
    vt[1] = '{1, 32'h41000000, 32'h40000000, 32'h40800000}; // 8/2
    vt[2] = '{2, 32'h40C00000, 32'h40000000, 32'h40400000}; // 6/2
    vt[3] = '{3, 32'h40400000, 32'h3FC00000, 32'h40000000}; // 3/1.5
    vt[4] = '{0, 32'hC1100000, 32'h40400000, 32'hC0400000}; // -9/3
    vt[5] = '{1, 32'h3F800000, 32'h41000000, 32'h3E000000}; // 1/8
    vt[6] = '{2, 32'h41200000, 32'h40800000, 32'h40200000}; // 10/4
    vt[7] = '{3, 32'h40E00000, 32'h3F000000, 32'h41600000}; // 7/0.5

    reset = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    clear_ops();
    for (int i = 0; i < NREQ; i++) exp_quot[i] = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_div_tvalid", 64'(div_tvalid), 64'h0);
    check("rst_div_dataa", 64'(div_dataa), 64'h0);
    check("rst_div_datab", 64'(div_datab), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", 64'(rsp_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h1);
    check("rst_err", 64'(err), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);

    // drain: all requesters waiting at release, a stray result injected mid-drain
    for (int v = 0; v < 4; v++) add_op(int'(vt[v].req), vt[v].a, vt[v].b, vt[v].q);
    @(posedge clk); #1;
    apply_inputs();
    reset = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 inj_v = 1'b1; inj_d = 32'h12345678;
        @(posedge clk);
        #1 inj_v = 1'b0;
      end
    join_none
    run_ops(200);
    check("drain_ready_low_cycles", 64'(first_ready_cyc), 64'(DIV_LAT + 2));
    wait_idle(200);
    check("drain_err", 64'(err), 64'h0);

    // round-robin: every requester holds valid for 8 grants
    clear_ops();
    grant_log.delete();
    for (int v = 0; v < 8; v++) add_op(int'(vt[v].req), vt[v].a, vt[v].b, vt[v].q);
    run_ops(100);
    wait_idle(200);
    check("rr_grant_count", 64'(grant_log.size()), 64'd8);
    for (int g = 0; g < 8 && g < grant_log.size(); g++) check("rr_grant_order", 64'(grant_log[g]), 64'(g % 4));

    // back-to-back: requesters 0 and 1 keep the pipeline full for 40 issues
    clear_ops();
    grant_log.delete();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      b = {1'b0, 8'(127 + k), 23'h0};
      q = {a[31], a[30:23] - 8'(k), a[22:0]};
      add_op(n % 2, a, b, q);
    end
    run_ops(200);
    wait_idle(200);
    check("b2b_grant_count", 64'(grant_log.size()), 64'd40);
    for (int g = 0; g < 40 && g < grant_log.size(); g++) check("b2b_alternate", 64'(grant_log[g]), 64'(g % 2));
    check("b2b_err", 64'(err), 64'h0);

    // single operation latency and busy fall
    clear_ops();
    add_op(2, 32'h40C00000, 32'h40000000, 32'h40400000);
    run_ops(50);
    wait_idle(100);
    check("single_rsp_valid", 64'(last_rsp_v), 64'h4);
    check("single_rsp_data", 64'(last_rsp_d), 64'h40400000);
    check("single_latency", 64'(rsp_cyc - acc_cyc), 64'(DIV_LAT + 2));
    check("single_busy_at_rsp", 64'(busy_at_rsp), 64'h1);
    check("single_busy_after", 64'(busy_after_rsp), 64'h0);

    // reset mid-flight: none of 5 results may surface
    clear_ops();
    for (int n = 0; n < 5; n++) add_op(n % 2, vt[n].a, vt[n].b, vt[n].q);
    run_ops(50);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    clear_ops();
    add_op(3, 32'h41200000, 32'h40800000, 32'h40200000);
    apply_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_state_drain", 64'(dbg_state), 64'h0);
    check("midrst_err", 64'(err), 64'h0);
    @(posedge clk); #1;
    run_ops(200);
    check("midrst_drain_cycles", 64'(first_ready_cyc), 64'(DIV_LAT + 2));
    wait_idle(200);
    check("midrst_rsp_valid", 64'(last_rsp_v), 64'h8);
    check("midrst_rsp_data", 64'(last_rsp_d), 64'h40200000);
    check("midrst_err_after", 64'(err), 64'h0);

    // orphan result with an empty tag FIFO
    repeat (5) @(posedge clk);
    #1 inj_v = 1'b1; inj_d = 32'h3F800000;
    @(posedge clk);
    #1 inj_v = 1'b0;
    @(negedge clk);
    check("orphan_err", 64'(err), 64'h1);
    check("orphan_rsp_valid", 64'(rsp_valid), 64'h0);
    repeat (5) @(negedge clk);
    check("orphan_err_sticky", 64'(err), 64'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("orphan_err_cleared", 64'(err), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_div_scheduler.md
# fp_div_scheduler

Shares the single-precision floating-point divider pipeline among NREQ requesters in the Kalman filter datapath, for example the gain computation and the covariance normalisation. The block grants one request per cycle by round-robin and drives the divider's operand channels. It tracks the owner of each in-flight operation in a tag FIFO and routes every quotient back to the requester that issued it. After reset it drains the divider pipeline, which has no reset of its own, before accepting new work.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIV_LAT, 28, divider latency in cycles from operand valid to result valid
- TAG_DEPTH, 32, tag FIFO depth, power of two, must be ≥ DIV_LAT+2
- clock  in  1  rising-edge clock for all logic
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  requester i holds an operation pending until accepted
- req_dataa  in  NREQ*32  dividend of requester i at bits [32i+31:32i]
- req_datab  in  NREQ*32  divisor of requester i, same packing
- req_ready  out  NREQ  combinational one-hot accept; the transfer occurs on the edge where valid&ready
- div_tvalid  out  1  registered operand valid; drives both divider a_tvalid and b_tvalid
- div_dataa, div_datab  out  32 each  registered operands
- div_result_tvalid  in  1  divider result valid
- div_result_tdata  in  32  divider quotient
- rsp_valid  out  NREQ  registered one-hot, 1-cycle pulse
- rsp_data  out  32  quotient, valid only with rsp_valid
- busy  out  1  high while in DRAIN or while any operation is outstanding
- err  out  1  sticky error flag; cleared only by reset

## Operation
- The state machine has two states: DRAIN and RUN. Reset enters DRAIN with the drain counter set to DIV_LAT+1.
- DRAIN:
  - req_ready is held at 0.
  - Every div_result_tvalid is discarded silently and does not set err.
  - The counter decrements each cycle. The block moves to RUN on the cycle after the counter reaches 0.
- RUN, arbitration:
  - The search starts at index last+1 modulo NREQ. The first i with req_valid[i] set receives req_ready[i]=1.
  - last is updated to i on a grant. After reset, last = NREQ-1, so requester 0 has highest priority.
- RUN, issue:
  - On a grant edge, div_tvalid<=1, div_dataa/div_datab<=operands of i, and tag i is pushed into the FIFO.
  - With no grant, div_tvalid<=0 and the operand registers hold their values.
- RUN, return:
  - On each div_result_tvalid, the block pops the head tag t.
  - Next cycle, rsp_valid[t]=1 and rsp_data=div_result_tdata.
  - If the FIFO is empty at that point, the result is dropped and err is set.
- A push and a pop on the same edge leave the FIFO count unchanged. Both must be supported.
- The divider never back-pressures, so at most DIV_LAT+1 tags are in flight. A push into a full FIFO sets err, and the push is dropped.
- Data is passed through bit-exact. The block performs no arithmetic on operands or results. Divide-by-zero and NaN results are the divider's responsibility.
- Reset asserted mid-operation:
  - The FIFO, rsp_valid, div_tvalid and err clear on the next edge.
  - Results of operations that were in flight arrive during DRAIN and are discarded.

## Timing
- Reset values:
  - req_ready=0, div_tvalid=0, div_dataa=0, div_datab=0
  - rsp_valid=0, rsp_data=0
  - busy=1, err=0
- Accept latency: req_ready is combinational in the same cycle as req_valid when the block is in RUN.
- Issue latency: div_tvalid is asserted 1 cycle after the accept edge.
- Request to response: DIV_LAT+2 cycles from the accept edge to the rsp_valid pulse.
- Throughput: 1 operation per cycle, shared across all requesters. A requester that keeps valid asserted gets at most 1 of every k grants when k requesters are active.
- Responses return in issue order because the divider is in-order.
- busy falls on the cycle after the last response when no requests are pending.

## Test plan
- Drain check: release reset and hold req_valid=4'b1111.
  - Required: req_ready stays 0 for exactly DIV_LAT+2 cycles.
  - Required: an injected div_result_tvalid during drain produces no rsp_valid and err stays 0.
- Single operation: requester 2 issues 0x40C00000/0x40000000 (6.0/2.0).
  - Required: rsp_valid=4'b0100 with rsp_data=0x40400000, DIV_LAT+2 cycles after accept.
- Round-robin: all 4 requesters hold valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: responses return in the same order, each with the correct quotient, e.g. 1.0/4.0 = 0x3F800000/0x40800000 -> 0x3E800000.
- Back-to-back full pipeline: requesters 0 and 1 keep valid asserted for 40 cycles.
  - Required: 40 responses alternate 0,1.
  - Required: a push and a pop occur on the same edge with no loss, and err stays 0.
- Reset mid-flight: assert reset 10 cycles after 5 issues.
  - Required: none of those 5 results appear on rsp_valid.
  - Required: the block re-enters DRAIN, and the first operation issued after drain returns correctly.
- Orphan result: in RUN with the FIFO empty, force div_result_tvalid=1.
  - Required: err=1 on the next cycle and stays set until reset.
  - Required: rsp_valid stays 0.
